// File: rtl/fft_frame_seq.sv
// Frame sequencer for the 2048-point FFT: streams a frame into the banks, starts the core,
// then drains the banks through a credit-limited skid FIFO as a bin-tagged output stream.
module fft_frame_seq #(
  parameter int unsigned DW         = 16,
  parameter int unsigned RAM_RD_LAT = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            iCLK,
  input  logic            iRESET,
  input  logic            iIN_VALID,
  input  logic [2*DW-1:0] iIN_DATA,
  output logic            oIN_READY,
  output logic            oFFT_START,
  input  logic            iFFT_RDY,
  output logic            oOWN,
  output logic [3:0]      oLD_WE,
  output logic [8:0]      oLD_ADDR,
  output logic [2*DW-1:0] oLD_DATA,
  output logic [1:0]      oUL_BANK,
  output logic [8:0]      oUL_ADDR,
  input  logic [8*DW-1:0] iRAM_Q,
  output logic            oOUT_VALID,
  output logic [2*DW-1:0] oOUT_DATA,
  output logic [10:0]     oOUT_BIN,
  output logic            oOUT_LAST,
  input  logic            iOUT_READY,
  output logic            oBUSY
);

  localparam int unsigned SW = 2 * DW;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + RAM_RD_LAT + 1);

  typedef enum logic [1:0] {StLoad, StKick, StRun, StUnload} state_e;

  state_e      state_q, state_d;
  logic [10:0] ld_cnt_q, ld_cnt_d;
  logic        seen_low_q, seen_low_d;
  logic [10:0] rd_cnt_q, rd_cnt_d;
  logic        rd_done_q, rd_done_d;

  logic [3:0]    ld_we_q;
  logic [8:0]    ld_addr_q;
  logic [SW-1:0] ld_data_q;

  logic          pipe_v_q [RAM_RD_LAT];
  logic [10:0]   pipe_m_q [RAM_RD_LAT];

  logic [SW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [10:0]   fifo_bin_q  [FIFO_DEPTH];
  logic          fifo_last_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q, inflight;

  logic          in_acc, issue, push, pop, head_last;
  logic [1:0]    cap_bank;
  logic [SW-1:0] cap_data;
  logic [10:0]   cap_m;

  // Radix-2 digit to the MSB, base-4 digits reversed.
  function automatic logic [10:0] bin_of(input logic [10:0] m);
    return {m[0], m[2:1], m[4:3], m[6:5], m[8:7], m[10:9]};
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_RD_LAT; i++) inflight = inflight + CW'(pipe_v_q[i]);
  end

  assign in_acc    = iIN_VALID && (state_q == StLoad);
  // Credit check keeps every issued read guaranteed a FIFO slot on return.
  assign issue     = (state_q == StUnload) && !rd_done_q &&
                     ((fifo_cnt_q + inflight) < CW'(FIFO_DEPTH));
  assign push      = pipe_v_q[RAM_RD_LAT-1];
  assign pop       = (fifo_cnt_q != '0) && iOUT_READY;
  assign head_last = fifo_last_q[rd_ptr_q];
  assign cap_m     = pipe_m_q[RAM_RD_LAT-1];
  assign cap_bank  = cap_m[10:9];

  always_comb begin
    cap_data = '0;
    unique case (cap_bank)
      2'd0: cap_data = iRAM_Q[SW-1:0];
      2'd1: cap_data = iRAM_Q[2*SW-1:SW];
      2'd2: cap_data = iRAM_Q[3*SW-1:2*SW];
      2'd3: cap_data = iRAM_Q[4*SW-1:3*SW];
      default: cap_data = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    seen_low_d = seen_low_q;
    rd_cnt_d   = rd_cnt_q;
    rd_done_d  = rd_done_q;
    unique case (state_q)
      StLoad: begin
        if (in_acc) begin
          ld_cnt_d = ld_cnt_q + 11'd1;
          if (ld_cnt_q == 11'd2047) state_d = StKick;
        end
      end
      StKick: begin
        seen_low_d = 1'b0;
        state_d    = StRun;
      end
      StRun: begin
        // A ready that never dropped after the kick is stale, not completion.
        if (!iFFT_RDY) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          seen_low_d = 1'b0;
          state_d    = StUnload;
        end
      end
      StUnload: begin
        if (issue) begin
          rd_cnt_d = rd_cnt_q + 11'd1;
          if (rd_cnt_q == 11'd2047) rd_done_d = 1'b1;
        end
        if (pop && head_last) begin
          state_d   = StLoad;
          ld_cnt_d  = '0;
          rd_cnt_d  = '0;
          rd_done_d = 1'b0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q    <= StLoad;
      ld_cnt_q   <= '0;
      seen_low_q <= 1'b0;
      rd_cnt_q   <= '0;
      rd_done_q  <= 1'b0;
      ld_we_q    <= '0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < RAM_RD_LAT; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_m_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      seen_low_q <= seen_low_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_done_q  <= rd_done_d;
      ld_we_q    <= in_acc ? (4'b0001 << ld_cnt_q[10:9]) : 4'b0000;
      if (in_acc) begin
        ld_addr_q <= ld_cnt_q[8:0];
        ld_data_q <= iIN_DATA;
      end
      pipe_v_q[0] <= issue;
      pipe_m_q[0] <= rd_cnt_q;
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_m_q[i] <= pipe_m_q[i-1];
      end
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= cap_data;
      fifo_bin_q[wr_ptr_q]  <= bin_of(cap_m);
      fifo_last_q[wr_ptr_q] <= (cap_m == 11'd2047);
    end
  end

  assign oIN_READY  = (state_q == StLoad);
  assign oFFT_START = (state_q == StKick);
  assign oOWN       = (state_q == StLoad) || (state_q == StUnload);
  assign oBUSY      = !((state_q == StLoad) && (ld_cnt_q == 11'd0));
  assign oLD_WE     = ld_we_q;
  assign oLD_ADDR   = ld_addr_q;
  assign oLD_DATA   = ld_data_q;
  assign oUL_BANK   = rd_cnt_q[10:9];
  assign oUL_ADDR   = rd_cnt_q[8:0];
  assign oOUT_VALID = (fifo_cnt_q != '0);
  // FIFO storage is not reset; gating keeps the outputs at zero while empty.
  assign oOUT_DATA  = oOUT_VALID ? fifo_data_q[rd_ptr_q] : '0;
  assign oOUT_BIN   = oOUT_VALID ? fifo_bin_q[rd_ptr_q] : '0;
  assign oOUT_LAST  = oOUT_VALID && head_last;

endmodule

// File: tb/tb_fft_frame_seq.sv
// Bench for fft_frame_seq: frame-level model (load order, RAM contents, bin order) plus
// per-cycle output scoreboard and a few literal expectations.
module tb_fft_frame_seq;
  localparam int DW    = 16;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic            iCLK = 1'b0;
  logic            iRESET = 1'b0;
  logic            iIN_VALID, oIN_READY, oFFT_START, iFFT_RDY, oOWN;
  logic [2*DW-1:0] iIN_DATA, oLD_DATA, oOUT_DATA;
  logic [3:0]      oLD_WE;
  logic [8:0]      oLD_ADDR, oUL_ADDR;
  logic [1:0]      oUL_BANK;
  logic [8*DW-1:0] iRAM_Q;
  logic            oOUT_VALID, oOUT_LAST, iOUT_READY, oBUSY;
  logic [10:0]     oOUT_BIN;

  fft_frame_seq #(.DW(DW), .RAM_RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iIN_VALID(iIN_VALID), .iIN_DATA(iIN_DATA),
    .oIN_READY(oIN_READY), .oFFT_START(oFFT_START), .iFFT_RDY(iFFT_RDY), .oOWN(oOWN),
    .oLD_WE(oLD_WE), .oLD_ADDR(oLD_ADDR), .oLD_DATA(oLD_DATA), .oUL_BANK(oUL_BANK),
    .oUL_ADDR(oUL_ADDR), .iRAM_Q(iRAM_Q), .oOUT_VALID(oOUT_VALID), .oOUT_DATA(oOUT_DATA),
    .oOUT_BIN(oOUT_BIN), .oOUT_LAST(oOUT_LAST), .iOUT_READY(iOUT_READY), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0, failures = 0;
  int frame_id = 0, starts = 0, credit_bad = 0, cb0 = 0;
  int ld_n = 0, ld_total = 0, cmp_idx;

  typedef struct {
    logic [31:0] d;
    logic [10:0] bin;
    logic        last;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  function automatic logic [31:0] sample(input int n, input int f);
    return {16'(n ^ (f << 12)), 16'(n * 5 + 3)};
  endfunction

  function automatic logic [31:0] data_of(input int m);
    return {16'(m + 4096), 16'(65535 - m)};
  endfunction

  // Bin: odd/even digit times 1024 plus the five base-4 digits of m/2 in reversed weight.
  function automatic logic [10:0] model_bin(input int m);
    int q = m / 2;
    int w = 256;
    int bin = (m % 2) * 1024;
    for (int k = 0; k < 5; k++) begin
      bin += (q % 4) * w;
      q = q / 4;
      w = w / 4;
    end
    return 11'(bin);
  endfunction

  // RAM model: every bank returns the frame location it holds, RAM_RD_LAT cycles later.
  logic [8:0] ra1, ra2;
  always @(posedge iCLK) begin
    ra1 <= oUL_ADDR;
    ra2 <= ra1;
  end
  always_comb begin
    iRAM_Q = '0;
    for (int b = 0; b < 4; b++) iRAM_Q[b*32 +: 32] = data_of(b * 512 + int'(ra2));
  end

  // Bank write checker: writes must appear in natural order, one per accepted sample.
  always @(negedge iCLK) begin
    if (iRESET && oLD_WE != 4'b0) begin
      check("ld_we", 64'(oLD_WE), 64'(4'b0001 << (ld_n / 512)));
      check("ld_addr", 64'(oLD_ADDR), 64'(ld_n % 512));
      check("ld_data", 64'(oLD_DATA), 64'(sample(ld_n, frame_id)));
      if (ld_n == 1500) begin
        check("ld_we_1500", 64'(oLD_WE), 64'(4'b0100));
        check("ld_addr_1500", 64'(oLD_ADDR), 64'd476);
      end
      ld_n = (ld_n + 1) % 2048;
      ld_total++;
    end
  end

  always @(negedge iCLK) begin
    if (iRESET && oFFT_START) begin
      starts++;
      check("own_at_kick", 64'(oOWN), 64'd0);
    end
  end

  // Output scoreboard and read-credit monitor.
  always @(negedge iCLK) begin
    if (iRESET) begin
      if (oOWN && !oIN_READY) begin
        if (int'({oUL_BANK, oUL_ADDR}) - (2048 - exp_q.size()) > DEPTH) credit_bad++;
      end
      if (oOUT_VALID) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_spurious: got valid=1 bin=%0d, required valid=0", oOUT_BIN);
        end else begin
          cmp_idx = 2048 - exp_q.size();
          check("out_data", 64'(oOUT_DATA), 64'(exp_q[0].d));
          check("out_bin", 64'(oOUT_BIN), 64'(exp_q[0].bin));
          check("out_last", 64'(oOUT_LAST), 64'(exp_q[0].last));
          if (cmp_idx == 1)    check("bin_m1", 64'(oOUT_BIN), 64'd1024);
          if (cmp_idx == 2)    check("bin_m2", 64'(oOUT_BIN), 64'd256);
          if (cmp_idx == 512)  check("bin_m512", 64'(oOUT_BIN), 64'd1);
          if (cmp_idx == 2047) check("last_m2047", 64'(oOUT_LAST), 64'd1);
          if (iOUT_READY) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic load_frame(input bit gaps);
    int n = 0;
    int guard = 0;
    while (n < 2048 && guard < 10000) begin
      iIN_VALID = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      iIN_DATA  = sample(n, frame_id);
      @(negedge iCLK);
      if (iIN_VALID && oIN_READY) n++;
      tick();
      guard++;
    end
    check("load_count", 64'(n), 64'd2048);
    iIN_VALID = 1'b1;
    iIN_DATA  = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge iCLK);
      check("in_ready_after_load", 64'(oIN_READY), 64'd0);
      tick();
    end
    iIN_VALID = 1'b0;
  endtask

  task automatic run_fft(input int hi, input int lo);
    int own_bad = 0;
    repeat (hi) begin
      @(negedge iCLK);
      if (oOWN) own_bad++;
      tick();
    end
    iFFT_RDY = 1'b0;
    repeat (lo) begin
      @(negedge iCLK);
      if (oOWN) own_bad++;
      tick();
    end
    iFFT_RDY = 1'b1;
    cb0 = credit_bad;
    for (int m = 0; m < 2048; m++) begin
      exp_t e;
      e.d    = data_of(m);
      e.bin  = model_bin(m);
      e.last = (m == 2047);
      exp_q.push_back(e);
    end
    check("own_low_in_run", 64'(own_bad), 64'd0);
    @(negedge iCLK);
    check("own_at_rdy_rise", 64'(oOWN), 64'd0);
    tick();
    @(negedge iCLK);
    check("own_unload_entry", 64'(oOWN), 64'd1);
  endtask

  task automatic unload(input bit rnd, input int reset_at);
    int k = 0;
    int span = 0;
    iOUT_READY = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
    while (!oOUT_VALID && k < 10) begin
      tick();
      iOUT_READY = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      @(negedge iCLK);
      k++;
    end
    check("first_valid_latency", 64'(k), 64'(LAT + 1));
    while (span < 20000) begin
      tick();
      span++;
      if (exp_q.size() == 0) break;
      if (reset_at >= 0 && 2048 - exp_q.size() == reset_at) begin
        iRESET = 1'b0;
        exp_q.delete();
        @(negedge iCLK);
        check("rst_mid_valid", 64'(oOUT_VALID), 64'd0);
        check("rst_mid_own", 64'(oOWN), 64'd1);
        tick();
        iRESET = 1'b1;
        @(negedge iCLK);
        check("post_rst_valid", 64'(oOUT_VALID), 64'd0);
        check("post_rst_in_ready", 64'(oIN_READY), 64'd1);
        check("post_rst_busy", 64'(oBUSY), 64'd0);
        tick();
        return;
      end
      iOUT_READY = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
    check("unload_drained", 64'(exp_q.size()), 64'd0);
    if (!rnd) check("unload_span", 64'(span), 64'd2048);
    check("credit_limit", 64'(credit_bad - cb0), 64'd0);
    @(negedge iCLK);
    check("back_to_load_ready", 64'(oIN_READY), 64'd1);
    check("back_to_load_busy", 64'(oBUSY), 64'd0);
    tick();
    iOUT_READY = 1'b0;
  endtask

  initial begin
    iIN_VALID  = 1'b0;
    iIN_DATA   = '0;
    iFFT_RDY   = 1'b1;
    iOUT_READY = 1'b0;
    iRESET     = 1'b0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_in_ready", 64'(oIN_READY), 64'd1);
    check("rst_own", 64'(oOWN), 64'd1);
    check("rst_start", 64'(oFFT_START), 64'd0);
    check("rst_out_valid", 64'(oOUT_VALID), 64'd0);
    check("rst_busy", 64'(oBUSY), 64'd0);
    check("rst_ld_we", 64'(oLD_WE), 64'd0);
    check("rst_out_last", 64'(oOUT_LAST), 64'd0);
    tick();
    iRESET = 1'b1;

    frame_id = 0;
    load_frame(1'b0);
    check("start_pulses_f0", 64'(starts), 64'd1);
    run_fft(10, 3000);
    unload(1'b0, -1);

    frame_id = 1;
    load_frame(1'b1);
    run_fft(2, 5);
    unload(1'b1, -1);
    check("start_pulses_f1", 64'(starts), 64'd2);

    frame_id = 2;
    load_frame(1'b0);
    run_fft(1, 4);
    unload(1'b0, 700);

    frame_id = 3;
    load_frame(1'b0);
    run_fft(3, 3);
    unload(1'b0, -1);
    check("start_pulses_total", 64'(starts), 64'd4);
    check("ld_writes_total", 64'(ld_total), 64'(4 * 2048));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
